// File: rtl/iob_2p_asym_fifo_ctrl_if.sv
// Client/RAM-facing bundle of the asymmetric FIFO controller.
// slave = controller side, master = producer/consumer plus RAM side.
interface iob_2p_asym_fifo_ctrl_if #(
    parameter int W_DATA_W = 32,
    parameter int W_ADDR_W = 2,
    parameter int R_DATA_W = 8,
    parameter int R_ADDR_W = 4
);
    localparam int LVL_W = ((W_ADDR_W > R_ADDR_W) ? W_ADDR_W : R_ADDR_W) + 1;

    logic                clr;
    logic                w_req;
    logic [W_DATA_W-1:0] w_data;
    logic                r_req;
    logic [R_DATA_W-1:0] r_data;
    logic                r_valid;
    logic                full;
    logic                empty;
    logic [LVL_W-1:0]    level;
    logic                w_ovf;
    logic                r_unf;
    logic                mem_w_en;
    logic [W_ADDR_W-1:0] mem_w_addr;
    logic [W_DATA_W-1:0] mem_w_data;
    logic                mem_r_en;
    logic [R_ADDR_W-1:0] mem_r_addr;
    logic [R_DATA_W-1:0] mem_r_data;

    modport slave (
        input  clr, w_req, w_data, r_req, mem_r_data,
        output r_data, r_valid, full, empty, level, w_ovf, r_unf,
               mem_w_en, mem_w_addr, mem_w_data, mem_r_en, mem_r_addr
    );

    modport master (
        output clr, w_req, w_data, r_req, mem_r_data,
        input  r_data, r_valid, full, empty, level, w_ovf, r_unf,
               mem_w_en, mem_w_addr, mem_w_data, mem_r_en, mem_r_addr
    );
endinterface

// File: rtl/iob_2p_asym_fifo_ctrl.sv
// Single-clock FIFO controller for an asymmetric two-port RAM.
// Occupancy and pointers count narrow-word units; flags are registered from level_next.
module iob_2p_asym_fifo_ctrl #(
    parameter int W_DATA_W = 32,
    parameter int W_ADDR_W = 2,
    parameter int R_DATA_W = 8,
    parameter int R_ADDR_W = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    iob_2p_asym_fifo_ctrl_if.slave       bus
);
    localparam int MAX_AW = (W_ADDR_W > R_ADDR_W) ? W_ADDR_W : R_ADDR_W;
    localparam int LVL_W  = MAX_AW + 1;
    localparam int CAP    = 2 ** MAX_AW;
    localparam int MIN_W  = (W_DATA_W < R_DATA_W) ? W_DATA_W : R_DATA_W;
    localparam int WU     = W_DATA_W / MIN_W;
    localparam int RU     = R_DATA_W / MIN_W;
    localparam int WU_SH  = $clog2(WU);
    localparam int RU_SH  = $clog2(RU);

    localparam logic [LVL_W-1:0] WU_L  = LVL_W'(WU);
    localparam logic [LVL_W-1:0] RU_L  = LVL_W'(RU);
    localparam logic [LVL_W-1:0] CAP_L = LVL_W'(CAP);

    logic [LVL_W-1:0] r_wptr, r_rptr, r_level;
    logic             r_full, r_empty, r_valid, r_w_ovf, r_r_unf;

    logic             w_w_acc, w_r_acc;
    logic [LVL_W-1:0] w_level_next, w_free_next;
    logic [LVL_W-2:0] w_wofs, w_rofs;

    // clr wins over requests, so nothing reaches the RAM in a clearing cycle
    assign w_w_acc = bus.w_req & ~r_full  & ~bus.clr;
    assign w_r_acc = bus.r_req & ~r_empty & ~bus.clr;

    assign w_level_next = r_level + (w_w_acc ? WU_L : '0) - (w_r_acc ? RU_L : '0);
    assign w_free_next  = CAP_L - w_level_next;

    // Unit offset within the RAM, scaled down to the port's word granularity
    assign w_wofs = r_wptr[LVL_W-2:0] >> WU_SH;
    assign w_rofs = r_rptr[LVL_W-2:0] >> RU_SH;

    assign bus.mem_w_en   = w_w_acc;
    assign bus.mem_w_addr = w_wofs[W_ADDR_W-1:0];
    assign bus.mem_w_data = bus.w_data;
    assign bus.mem_r_en   = w_r_acc;
    assign bus.mem_r_addr = w_rofs[R_ADDR_W-1:0];
    assign bus.r_data     = bus.mem_r_data;
    assign bus.r_valid    = r_valid;
    assign bus.full       = r_full;
    assign bus.empty      = r_empty;
    assign bus.level      = r_level;
    assign bus.w_ovf      = r_w_ovf;
    assign bus.r_unf      = r_r_unf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_valid <= 1'b0;
            r_w_ovf <= 1'b0;
            r_r_unf <= 1'b0;
        end else if (bus.clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_valid <= 1'b0;
            r_w_ovf <= 1'b0;
            r_r_unf <= 1'b0;
        end else begin
            if (w_w_acc) r_wptr <= r_wptr + WU_L;
            if (w_r_acc) r_rptr <= r_rptr + RU_L;
            r_level <= w_level_next;
            r_full  <= (w_free_next < WU_L);
            r_empty <= (w_level_next < RU_L);
            r_valid <= w_r_acc;
            r_w_ovf <= bus.w_req & r_full;
            r_r_unf <= bus.r_req & r_empty;
        end
    end
endmodule

// File: tb/tb_iob_2p_asym_fifo_ctrl.sv
// Scoreboard bench: W32/R8 and W8/R32 controllers side by side, each with a RAM
// model and a unit-queue reference; a negedge monitor checks every cycle.
module tb_iob_2p_asym_fifo_ctrl;
    localparam int CAP = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    iob_2p_asym_fifo_ctrl_if #(.W_DATA_W(32), .W_ADDR_W(2), .R_DATA_W(8),  .R_ADDR_W(4)) ifa ();
    iob_2p_asym_fifo_ctrl_if #(.W_DATA_W(8),  .W_ADDR_W(4), .R_DATA_W(32), .R_ADDR_W(2)) ifb ();

    iob_2p_asym_fifo_ctrl #(.W_DATA_W(32), .W_ADDR_W(2), .R_DATA_W(8), .R_ADDR_W(4))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    iob_2p_asym_fifo_ctrl #(.W_DATA_W(8), .W_ADDR_W(4), .R_DATA_W(32), .R_ADDR_W(2))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    // Byte-addressed RAM models with registered read data, never reset
    logic [7:0] mem_a [16];
    logic [7:0] mem_b [16];
    always @(posedge clk) begin
        if (ifa.mem_w_en)
            for (int k = 0; k < 4; k++) mem_a[int'(ifa.mem_w_addr)*4+k] <= ifa.mem_w_data[8*k+:8];
        if (ifa.mem_r_en) ifa.mem_r_data <= mem_a[ifa.mem_r_addr];
        if (ifb.mem_w_en) mem_b[ifb.mem_w_addr] <= ifb.mem_w_data;
        if (ifb.mem_r_en)
            for (int k = 0; k < 4; k++) ifb.mem_r_data[8*k+:8] <= mem_b[int'(ifb.mem_r_addr)*4+k];
    end

    // Reference model: FIFO of byte units, occupancy = queue size
    logic [7:0]  bq   [2][$];
    logic [31:0] expq [2][$];
    int m_level [2], m_wcnt [2], m_rcnt [2];
    bit m_ovf [2], m_unf [2], m_rv [2];
    bit nx_ovf [2], nx_unf [2], nx_rv [2];
    bit p_wen [2], p_ren [2];
    int p_waddr [2], p_raddr [2];
    int n_vec = 0, n_err = 0;
    bit done = 0, fin = 0;

    function automatic int wu(input int c); return (c == 0) ? 4 : 1; endfunction
    function automatic int ru(input int c); return (c == 0) ? 1 : 4; endfunction

    task automatic model_cycle(input int c, input bit w, input bit r, input bit cl, input logic [31:0] wd);
        bit fullf, emptyf;
        logic [31:0] word;
        p_wen[c]   = 0;
        p_ren[c]   = 0;
        p_waddr[c] = (m_wcnt[c] % CAP) / wu(c);
        p_raddr[c] = (m_rcnt[c] % CAP) / ru(c);
        if (cl) begin
            m_wcnt[c] = 0; m_rcnt[c] = 0; bq[c].delete();
            nx_ovf[c] = 0; nx_unf[c] = 0; nx_rv[c] = 0;
            return;
        end
        fullf  = (CAP - bq[c].size()) < wu(c);
        emptyf = bq[c].size() < ru(c);
        p_wen[c]  = w && !fullf;
        p_ren[c]  = r && !emptyf;
        nx_ovf[c] = w && fullf;
        nx_unf[c] = r && emptyf;
        nx_rv[c]  = p_ren[c];
        if (p_ren[c]) begin
            word = '0;
            for (int k = 0; k < ru(c); k++) word[8*k+:8] = bq[c].pop_front();
            expq[c].push_back(word);
            m_rcnt[c] += ru(c);
        end
        if (p_wen[c]) begin
            for (int k = 0; k < wu(c); k++) bq[c].push_back(wd[8*k+:8]);
            m_wcnt[c] += wu(c);
        end
    endtask

    task automatic drive(input bit w, input bit r, input logic [31:0] wda, input logic [7:0] wdb, input bit cl);
        ifa.w_req = w; ifa.r_req = r; ifa.w_data = wda; ifa.clr = cl;
        ifb.w_req = w; ifb.r_req = r; ifb.w_data = wdb; ifb.clr = cl;
    endtask

    task automatic step(input bit w, input bit r, input logic [31:0] wda, input logic [7:0] wdb, input bit cl);
        drive(w, r, wda, wdb, cl);
        model_cycle(0, w, r, cl, wda);
        model_cycle(1, w, r, cl, {24'h0, wdb});
        @(posedge clk); #1;
        for (int c = 0; c < 2; c++) begin
            m_level[c] = bq[c].size();
            m_ovf[c] = nx_ovf[c]; m_unf[c] = nx_unf[c]; m_rv[c] = nx_rv[c];
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, '0, '0, 0);
        for (int c = 0; c < 2; c++) begin
            bq[c].delete(); expq[c].delete();
            m_level[c] = 0; m_wcnt[c] = 0; m_rcnt[c] = 0;
            m_ovf[c] = 0; m_unf[c] = 0; m_rv[c] = 0;
            p_wen[c] = 0; p_ren[c] = 0;
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cfg%0d t=%0t: got %h expected %h", nm, c, $time, act, exp);
        end
    endtask

    task automatic check_cfg(input int c, input logic wen, input logic [31:0] wa, input logic ren,
                             input logic [31:0] ra, input logic [31:0] lvl, input logic fu,
                             input logic em, input logic ov, input logic un, input logic rv,
                             input logic [31:0] rd);
        chk("mem_w_en", c, {31'h0, wen}, {31'h0, p_wen[c]});
        if (p_wen[c]) chk("mem_w_addr", c, wa, p_waddr[c]);
        chk("mem_r_en", c, {31'h0, ren}, {31'h0, p_ren[c]});
        if (p_ren[c]) chk("mem_r_addr", c, ra, p_raddr[c]);
        chk("level", c, lvl, m_level[c]);
        chk("full",  c, {31'h0, fu}, {31'h0, (CAP - m_level[c]) < wu(c)});
        chk("empty", c, {31'h0, em}, {31'h0, m_level[c] < ru(c)});
        chk("w_ovf", c, {31'h0, ov}, {31'h0, m_ovf[c]});
        chk("r_unf", c, {31'h0, un}, {31'h0, m_unf[c]});
        chk("r_valid", c, {31'h0, rv}, {31'h0, m_rv[c]});
        if (rv === 1'b1) begin
            if (expq[c].size() == 0) chk("r_extra", c, {31'h0, rv}, 32'h0);
            else chk("r_data", c, rd, expq[c].pop_front());
        end
    endtask

    always @(negedge clk) begin
        check_cfg(0, ifa.mem_w_en, 32'(ifa.mem_w_addr), ifa.mem_r_en, 32'(ifa.mem_r_addr),
                  32'(ifa.level), ifa.full, ifa.empty, ifa.w_ovf, ifa.r_unf, ifa.r_valid, 32'(ifa.r_data));
        check_cfg(1, ifb.mem_w_en, 32'(ifb.mem_w_addr), ifb.mem_r_en, 32'(ifb.mem_r_addr),
                  32'(ifb.level), ifb.full, ifb.empty, ifb.w_ovf, ifb.r_unf, ifb.r_valid, 32'(ifb.r_data));
        if (done && !fin) begin
            for (int c = 0; c < 2; c++) chk("drain", c, 32'(expq[c].size()), 32'h0);
            fin = 1;
        end
    end

    initial begin
        do_reset();
        // empty start, refused read
        step(0, 0, '0, '0, 0);
        step(0, 1, '0, '0, 0);
        // fill: A takes 4 words then overflows, B takes 16 bytes
        for (int i = 0; i < 17; i++)
            step(1, 0, 32'h23222120 + 32'(i) * 32'h04040404, 8'(8'h20 + i), 0);
        // drain in order
        for (int i = 0; i < 17; i++) step(0, 1, '0, '0, 0);
        step(0, 0, '0, '0, 0);
        // simultaneous read and write from a partial level
        step(1, 0, 32'h33323130, 8'h30, 0);
        step(0, 1, '0, '0, 0);
        step(1, 1, 32'h37363534, 8'h31, 0);
        step(0, 0, '0, '0, 1);
        // wrap rounds
        for (int rd = 0; rd < 3; rd++) begin
            for (int i = 0; i < 4; i++) step(1, 0, $urandom(), 8'($urandom()), 0);
            for (int i = 0; i < 16; i++) step(0, 1, '0, '0, 0);
        end
        // mid-stream clr then reset, each followed by a write landing at address 0
        for (int i = 0; i < 3; i++) step(1, 1, $urandom(), 8'($urandom()), 0);
        step(1, 1, $urandom(), '0, 1);
        step(1, 0, $urandom(), 8'($urandom()), 0);
        for (int i = 0; i < 3; i++) step(1, 1, $urandom(), 8'($urandom()), 0);
        step(0, 1, '0, '0, 0);
        do_reset();
        step(1, 0, $urandom(), 8'($urandom()), 0);
        // randomized traffic with occasional clear and one reset
        for (int i = 0; i < 800; i++) begin
            if (i == 400) do_reset();
            step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
                 $urandom(), 8'($urandom()), $urandom_range(0, 99) == 0);
        end
        repeat (4) step(0, 0, '0, '0, 0);
        done = 1;
        @(negedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
